// File: rtl/jtdd_rom_arb.sv
// jtdd_rom_arb: shares one SDRAM ROM read port between the main CPU (0),
// the sound CPU (1) and the MCU (2). Each requester owns a one-entry cache
// (address + byte), so repeated reads of the same byte return with no latency.
// Misses are served one at a time with a round-robin pointer.
module jtdd_rom_arb #(
    parameter int unsigned AW0  = 18,
    parameter int unsigned AW1  = 15,
    parameter int unsigned AW2  = 14,
    parameter logic [21:0] OFF1 = 22'h04_0000,
    parameter logic [21:0] OFF2 = 22'h05_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,
    input  logic           cpu0_cs,
    input  logic [AW0-1:0] cpu0_addr,
    output logic [7:0]     cpu0_data,
    output logic           cpu0_ok,
    input  logic           cpu1_cs,
    input  logic [AW1-1:0] cpu1_addr,
    output logic [7:0]     cpu1_data,
    output logic           cpu1_ok,
    input  logic           cpu2_cs,
    input  logic [AW2-1:0] cpu2_addr,
    output logic [7:0]     cpu2_data,
    output logic           cpu2_ok,
    output logic           sdram_req,
    output logic [21:0]    sdram_addr,
    input  logic [7:0]     sdram_data,
    input  logic           sdram_ok
);

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic [1:0]     ptr_q, ptr_d;
    logic           req_q, req_d;
    logic [21:0]    addr_q, addr_d;
    logic [AW0-1:0] caddr0_q, caddr0_d;
    logic [AW1-1:0] caddr1_q, caddr1_d;
    logic [AW2-1:0] caddr2_q, caddr2_d;
    logic [7:0]     cdata0_q, cdata0_d;
    logic [7:0]     cdata1_q, cdata1_d;
    logic [7:0]     cdata2_q, cdata2_d;
    logic [2:0]     cvalid_q, cvalid_d;

    logic [2:0]     hit;
    logic [2:0]     miss;
    logic [21:0]    full0, full1, full2;
    logic [1:0]     sel;
    logic           sel_valid;
    logic [1:0]     cand;

    // Hits are combinational so a cached byte is returned in the same cycle
    assign hit[0] = cpu0_cs & cvalid_q[0] & (cpu0_addr == caddr0_q);
    assign hit[1] = cpu1_cs & cvalid_q[1] & (cpu1_addr == caddr1_q);
    assign hit[2] = cpu2_cs & cvalid_q[2] & (cpu2_addr == caddr2_q);
    assign miss   = {cpu2_cs, cpu1_cs, cpu0_cs} & ~hit;

    assign cpu0_ok    = hit[0];
    assign cpu1_ok    = hit[1];
    assign cpu2_ok    = hit[2];
    assign cpu0_data  = cdata0_q;
    assign cpu1_data  = cdata1_q;
    assign cpu2_data  = cdata2_q;
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;

    // SDRAM byte addresses; the 22-bit sums wrap rather than saturate
    assign full0 = 22'(cpu0_addr);
    assign full1 = 22'(cpu1_addr) + OFF1;
    assign full2 = 22'(cpu2_addr) + OFF2;

    // Round-robin pick: first missing requester at ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        sel       = 2'd0;
        sel_valid = 1'b0;
        cand      = ptr_q;
        for (int i = 0; i < 3; i++) begin
            if (!sel_valid && miss[cand]) begin
                sel       = cand;
                sel_valid = 1'b1;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    // Next-state logic: grant on a miss in idle, fill the cache on sdram_ok
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        req_d    = req_q;
        addr_d   = addr_q;
        caddr0_d = caddr0_q;
        caddr1_d = caddr1_q;
        caddr2_d = caddr2_q;
        cdata0_d = cdata0_q;
        cdata1_d = cdata1_q;
        cdata2_d = cdata2_q;
        cvalid_d = cvalid_q;
        unique case (state_q)
            StIdle: begin
                if (!downloading && sel_valid) begin
                    gnt_d   = sel;
                    req_d   = 1'b1;
                    state_d = StWait;
                    case (sel)
                        2'd0: begin
                            caddr0_d    = cpu0_addr;
                            addr_d      = full0;
                            cvalid_d[0] = 1'b0;
                        end
                        2'd1: begin
                            caddr1_d    = cpu1_addr;
                            addr_d      = full1;
                            cvalid_d[1] = 1'b0;
                        end
                        default: begin
                            caddr2_d    = cpu2_addr;
                            addr_d      = full2;
                            cvalid_d[2] = 1'b0;
                        end
                    endcase
                end
            end
            StWait: begin
                if (sdram_ok) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                    ptr_d   = (gnt_q == 2'd2) ? 2'd0 : gnt_q + 2'd1;
                    case (gnt_q)
                        2'd0: begin
                            cdata0_d    = sdram_data;
                            cvalid_d[0] = 1'b1;
                        end
                        2'd1: begin
                            cdata1_d    = sdram_data;
                            cvalid_d[1] = 1'b1;
                        end
                        default: begin
                            cdata2_d    = sdram_data;
                            cvalid_d[2] = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
        // A download rewrites the ROM, so no cached byte may survive it
        if (downloading) cvalid_d = 3'b000;
    end

    // State and cache registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            gnt_q    <= 2'd0;
            ptr_q    <= 2'd0;
            req_q    <= 1'b0;
            addr_q   <= 22'd0;
            caddr0_q <= '0;
            caddr1_q <= '0;
            caddr2_q <= '0;
            cdata0_q <= 8'd0;
            cdata1_q <= 8'd0;
            cdata2_q <= 8'd0;
            cvalid_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            caddr0_q <= caddr0_d;
            caddr1_q <= caddr1_d;
            caddr2_q <= caddr2_d;
            cdata0_q <= cdata0_d;
            cdata1_q <= cdata1_d;
            cdata2_q <= cdata2_d;
            cvalid_q <= cvalid_d;
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: an SDRAM responder model returns a byte derived from
// the address; a monitor pops the expected address queue on every new request.
module tb_jtdd_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        cpu0_cs, cpu1_cs, cpu2_cs;
    logic [17:0] cpu0_addr;
    logic [14:0] cpu1_addr;
    logic [13:0] cpu2_addr;
    logic [7:0]  cpu0_data, cpu1_data, cpu2_data;
    logic        cpu0_ok, cpu1_ok, cpu2_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [7:0]  sdram_data;
    logic        sdram_ok;

    int          n_pass = 0;
    int          n_total = 0;
    logic [21:0] exp_q[$];
    int          req_count = 0;
    bit          resp_en = 1'b0;
    int          resp_lat = 4;
    int          resp_cnt = 0;
    time         ok_time = 0;
    logic        mon_prev = 1'b0;
    logic [21:0] mon_held = 22'd0;
    logic [21:0] mon_exp;

    jtdd_rom_arb dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .cpu0_cs    (cpu0_cs),
        .cpu0_addr  (cpu0_addr),
        .cpu0_data  (cpu0_data),
        .cpu0_ok    (cpu0_ok),
        .cpu1_cs    (cpu1_cs),
        .cpu1_addr  (cpu1_addr),
        .cpu1_data  (cpu1_data),
        .cpu1_ok    (cpu1_ok),
        .cpu2_cs    (cpu2_cs),
        .cpu2_addr  (cpu2_addr),
        .cpu2_data  (cpu2_data),
        .cpu2_ok    (cpu2_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_data (sdram_data),
        .sdram_ok   (sdram_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h25;
    endfunction

    // SDRAM model: answers a held request after resp_lat cycles with a 1-cycle ok
    initial begin
        sdram_ok   = 1'b0;
        sdram_data = 8'd0;
        forever begin
            @(negedge clk);
            if (!resp_en || rst) begin
                resp_cnt = 0;
            end else if (sdram_ok) begin
                sdram_ok = 1'b0;
            end else if (sdram_req) begin
                resp_cnt++;
                if (resp_cnt >= resp_lat) begin
                    sdram_ok   = 1'b1;
                    sdram_data = rom_byte(sdram_addr);
                    ok_time    = $time;
                    resp_cnt   = 0;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Monitor: each rising sdram_req must match the next queued address
    initial begin
        forever begin
            @(negedge clk);
            if (sdram_req && !mon_prev) begin
                req_count++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL req_addr: unexpected request at %h, none queued", sdram_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (sdram_addr !== mon_exp)
                        $display("FAIL req_addr: got %h, required %h", sdram_addr, mon_exp);
                    else
                        n_pass++;
                end
                mon_held = sdram_addr;
            end else if (sdram_req) begin
                n_total++;
                if (sdram_addr !== mon_held)
                    $display("FAIL addr_stable: got %h, required %h", sdram_addr, mon_held);
                else
                    n_pass++;
            end
            mon_prev = sdram_req;
        end
    end

    task automatic test_reset;
        rst = 1'b1; downloading = 1'b0;
        cpu0_cs = 1'b0; cpu1_cs = 1'b0; cpu2_cs = 1'b0;
        cpu0_addr = '0; cpu1_addr = '0; cpu2_addr = '0;
        repeat (3) @(negedge clk);
        cpu0_cs = 1'b1; cpu1_cs = 1'b1; cpu2_cs = 1'b1;
        #1;
        n_total++;
        if (sdram_req !== 1'b0) $display("FAIL rst_req: got %b, required 0", sdram_req);
        else n_pass++;
        n_total++;
        if (sdram_addr !== 22'd0) $display("FAIL rst_addr: got %h, required 0", sdram_addr);
        else n_pass++;
        n_total++;
        if ({cpu2_ok, cpu1_ok, cpu0_ok} !== 3'b000)
            $display("FAIL rst_ok: got %b, required 000", {cpu2_ok, cpu1_ok, cpu0_ok});
        else n_pass++;
        n_total++;
        if ({cpu2_data, cpu1_data, cpu0_data} !== 24'h0)
            $display("FAIL rst_data: got %h, required 0", {cpu2_data, cpu1_data, cpu0_data});
        else n_pass++;
        cpu0_cs = 1'b0; cpu1_cs = 1'b0; cpu2_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic test_single_miss;
        bit found = 1'b0;
        @(negedge clk);
        exp_q.push_back(22'h008000);
        cpu0_addr = 18'h08000;
        cpu0_cs   = 1'b1;
        @(negedge clk);
        n_total++;
        if (sdram_req !== 1'b1) $display("FAIL miss_latency: req got %b, required 1", sdram_req);
        else n_pass++;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cpu0_ok === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found) begin
            $display("FAIL miss_ok: cpu0_ok got 0 after 40 cycles, required 1");
        end else begin
            n_pass++;
            n_total++;
            if (($time - ok_time) !== 10)
                $display("FAIL ok_latency: got %0t after sdram_ok, required 10", $time - ok_time);
            else n_pass++;
            n_total++;
            if (cpu0_data !== 8'hA5) $display("FAIL miss_data: got %h, required a5", cpu0_data);
            else n_pass++;
        end
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (cpu0_ok !== 1'b1 || sdram_req !== 1'b0)
                $display("FAIL hold_hit: ok/req got %b%b, required 10", cpu0_ok, sdram_req);
            else n_pass++;
        end
        cpu0_cs = 1'b0;
        @(negedge clk);
        cpu0_cs = 1'b1;
        #1;
        n_total++;
        if (cpu0_ok !== 1'b1) $display("FAIL hit_same_cycle: got %b, required 1", cpu0_ok);
        else n_pass++;
        cpu0_cs = 1'b0;
    endtask

    task automatic test_offset;
        bit found = 1'b0;
        @(negedge clk);
        exp_q.push_back(22'h050123);
        cpu2_addr = 14'h0123;
        cpu2_cs   = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cpu2_ok === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL offset_ok: cpu2_ok got 0, required 1");
        else if (cpu2_data !== rom_byte(22'h050123))
            $display("FAIL offset_data: got %h, required %h", cpu2_data, rom_byte(22'h050123));
        else n_pass++;
        cpu2_cs = 1'b0;
    endtask

    task automatic test_round_robin;
        bit found = 1'b0;
        int first = -1;
        @(negedge clk);
        exp_q.push_back(22'h000100);
        exp_q.push_back(22'h040200);
        exp_q.push_back(22'h050300);
        cpu0_addr = 18'h00100; cpu1_addr = 15'h0200; cpu2_addr = 14'h0300;
        cpu0_cs = 1'b1; cpu1_cs = 1'b1; cpu2_cs = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (cpu0_ok && cpu1_ok && cpu2_ok) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL rr_all_ok: got %b, required 111", {cpu2_ok, cpu1_ok, cpu0_ok});
        else n_pass++;
        n_total++;
        if ({cpu0_data, cpu1_data, cpu2_data} !==
            {rom_byte(22'h000100), rom_byte(22'h040200), rom_byte(22'h050300)})
            $display("FAIL rr_data: got %h %h %h, required %h %h %h", cpu0_data, cpu1_data,
                     cpu2_data, rom_byte(22'h000100), rom_byte(22'h040200),
                     rom_byte(22'h050300));
        else n_pass++;
        // Pointer is back at 0 after serving 2, so 0 goes before 1
        @(negedge clk);
        exp_q.push_back(22'h000101);
        exp_q.push_back(22'h040201);
        cpu2_cs = 1'b0;
        cpu0_addr = 18'h00101; cpu1_addr = 15'h0201;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (first < 0 && cpu1_ok) first = 1;
            if (first < 0 && cpu0_ok) first = 0;
            if (cpu0_ok && cpu1_ok) found = 1'b1;
        end
        n_total++;
        if (!found || first != 0)
            $display("FAIL rr_second: done %b first %0d, required done 1 first 0", found, first);
        else n_pass++;
        n_total++;
        if (cpu1_data !== rom_byte(22'h040201))
            $display("FAIL rr_second_data: got %h, required %h", cpu1_data, rom_byte(22'h040201));
        else n_pass++;
        cpu0_cs = 1'b0; cpu1_cs = 1'b0;
    endtask

    task automatic test_addr_change;
        bit found = 1'b0;
        int base;
        @(negedge clk);
        base = req_count;
        exp_q.push_back(22'h040010);
        cpu1_addr = 15'h0010;
        cpu1_cs   = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (sdram_req === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL chg_req: req got 0, required 1");
        else n_pass++;
        exp_q.push_back(22'h040011);
        cpu1_addr = 15'h0011;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (cpu1_ok === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found || (req_count - base) != 2)
            $display("FAIL chg_refetch: ok %b after %0d requests, required 1 after 2", found,
                     req_count - base);
        else n_pass++;
        n_total++;
        if (cpu1_data !== rom_byte(22'h040011))
            $display("FAIL chg_data: got %h, required %h", cpu1_data, rom_byte(22'h040011));
        else n_pass++;
        cpu1_cs = 1'b0;
    endtask

    task automatic test_download;
        bit found = 1'b0;
        int base;
        @(negedge clk);
        cpu0_addr = 18'h00101;
        cpu0_cs   = 1'b1;
        #1;
        n_total++;
        if (cpu0_ok !== 1'b1) $display("FAIL dl_pre_hit: got %b, required 1", cpu0_ok);
        else n_pass++;
        downloading = 1'b1;
        base = req_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (cpu0_ok !== 1'b0 || sdram_req !== 1'b0)
                $display("FAIL dl_block: ok/req got %b%b, required 00", cpu0_ok, sdram_req);
            else n_pass++;
        end
        exp_q.push_back(22'h000101);
        downloading = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (cpu0_ok === 1'b1) found = 1'b1;
        end
        n_total++;
        if (!found || (req_count - base) != 1 || cpu0_data !== rom_byte(22'h000101))
            $display("FAIL dl_refetch: ok %b reqs %0d data %h, required 1 1 %h", found,
                     req_count - base, cpu0_data, rom_byte(22'h000101));
        else n_pass++;
        cpu0_cs = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        bit found = 1'b0;
        resp_en = 1'b0;
        @(negedge clk);
        exp_q.push_back(22'h050400);
        cpu2_addr = 14'h0400;
        cpu2_cs   = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (sdram_req === 1'b1) found = 1'b1;
        end
        rst = 1'b1;
        #1;
        n_total++;
        if (sdram_req !== 1'b0 || {cpu2_ok, cpu1_ok, cpu0_ok} !== 3'b000)
            $display("FAIL rst_mid: req %b ok %b, required 0 000", sdram_req,
                     {cpu2_ok, cpu1_ok, cpu0_ok});
        else n_pass++;
        cpu2_cs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sdram_data = 8'hEE;
        sdram_ok   = 1'b1;
        @(negedge clk);
        sdram_ok = 1'b0;
        exp_q.push_back(22'h000101);
        exp_q.push_back(22'h050400);
        cpu0_addr = 18'h00101;
        cpu0_cs = 1'b1; cpu2_cs = 1'b1;
        #1;
        n_total++;
        if ({cpu2_ok, cpu0_ok} !== 2'b00)
            $display("FAIL late_ok: ok2/ok0 got %b, required 00", {cpu2_ok, cpu0_ok});
        else n_pass++;
        resp_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (cpu0_ok && cpu2_ok) found = 1'b1;
        end
        n_total++;
        if (!found || cpu2_data !== rom_byte(22'h050400))
            $display("FAIL post_rst_fetch: ok %b data %h, required 1 %h", found, cpu2_data,
                     rom_byte(22'h050400));
        else n_pass++;
        cpu0_cs = 1'b0; cpu2_cs = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_offset();
        test_round_robin();
        test_addr_change();
        test_download();
        test_reset_mid_wait();
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
